// File: rtl/mem_wb_stage.sv
// Memory stage and M->W pipeline register.
// Word-wide LW/SW against an internal data RAM, a combinational load-data
// forwarding tap, and sticky/saturating bookkeeping of faulting accesses.
module mem_wb_stage #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        M_op,
    input  logic [31:0]       M_valE,
    input  logic [31:0]       M_valA,
    input  logic [4:0]        M_dstE,
    input  logic [4:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [31:0]       m_valM,
    output logic              m_err,
    output logic [5:0]        W_op,
    output logic [31:0]       W_valE,
    output logic [31:0]       W_valM,
    output logic [4:0]        W_dstE,
    output logic [4:0]        W_dstM,
    output logic              W_err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam int         DEPTH = 2 ** ADDR_W;

    // RAM starts out zeroed and is deliberately left alone by rst.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic              is_lw;
    logic              is_sw;
    logic              is_mem;
    logic              misaligned;
    logic              out_of_range;
    logic [ADDR_W-1:0] waddr;
    logic              advance;
    logic              store_en;

    // Decode the M-stage access and flag faults before touching the RAM.
    always_comb begin
        is_lw        = (M_op == OP_LW);
        is_sw        = (M_op == OP_SW);
        is_mem       = is_lw | is_sw;
        waddr        = M_valE[ADDR_W+1:2];
        misaligned   = (M_valE[1:0] != 2'b00);
        out_of_range = |(M_valE >> (ADDR_W + 2));
        m_err        = is_mem & (misaligned | out_of_range);
        m_valM       = (is_lw && !m_err) ? mem[waddr] : 32'h0;
        dbg_data     = mem[dbg_addr];
        advance      = !rst && !W_stall && !W_bubble;
        store_en     = advance && is_sw && !m_err;
    end

    // Stores commit only on cycles where the instruction moves into W.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[waddr] <= M_valA;
        end
    end

    // W register and error bookkeeping: rst > stall > bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            W_op       <= '0;
            W_valE     <= '0;
            W_valM     <= '0;
            W_dstE     <= '0;
            W_dstM     <= '0;
            W_err      <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (W_stall) begin
            W_op       <= W_op;
        end else if (W_bubble) begin
            W_op       <= '0;
            W_valE     <= '0;
            W_valM     <= '0;
            W_dstE     <= '0;
            W_dstM     <= '0;
            W_err      <= 1'b0;
        end else begin
            W_op       <= M_op;
            W_valE     <= M_valE;
            W_valM     <= m_valM;
            W_err      <= m_err;
            if (m_err) begin
                // A faulting instruction must not write back any register.
                W_dstE     <= '0;
                W_dstM     <= '0;
                err_sticky <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end else begin
                W_dstE     <= M_dstE;
                W_dstM     <= M_dstM;
            end
        end
    end

endmodule
